// File: rtl/rvc_dmem_arb_5pl_pkg.sv
// ----------------------------------------------------------------------------
// rvc_dmem_arb_5pl_pkg
// Shared types and defaults for the D_MEM core/host arbiter.
// Rev 1.0 - initial release
// ----------------------------------------------------------------------------
`default_nettype none

package rvc_dmem_arb_5pl_pkg;

  // Host-side transaction tracker states
  typedef enum logic [1:0] {
    H_IDLE = 2'd0,
    H_RD   = 2'd1,
    H_ACK  = 2'd2,
    H_RSP  = 2'd3
  } t_host_state;

  localparam int DMEM_ARB_HOST_MAX_WAIT = 8;
  localparam int PERF_CNT_W             = 16;

endpackage

`default_nettype wire

// File: rtl/rvc_dmem_arb_5pl_sat_cnt.sv
// ----------------------------------------------------------------------------
// rvc_dmem_arb_5pl_sat_cnt
// Up-counter with synchronous clear; saturates at MAX_VAL or wraps.
// Rev 1.0 - initial release
// ----------------------------------------------------------------------------
`default_nettype none

module rvc_dmem_arb_5pl_sat_cnt #(
  parameter int               WIDTH    = 4,
  parameter bit               SATURATE = 1'b1,
  parameter logic [WIDTH-1:0] MAX_VAL  = '1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             inc,
  output logic [WIDTH-1:0] cnt
);

  logic at_max;
  assign at_max = SATURATE && (cnt == MAX_VAL);

  // Count register: clear has priority, then increment unless pinned at max
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (inc && !at_max) begin
      cnt <= cnt + {{(WIDTH-1){1'b0}}, 1'b1};
    end
  end

endmodule

`default_nettype wire

// File: rtl/rvc_dmem_arb_5pl.sv
// ----------------------------------------------------------------------------
// rvc_dmem_arb_5pl
// Single-port D_MEM arbiter: core has default priority, host is guaranteed
// a slot after HOST_MAX_WAIT pending cycles. Optional performance counters
// are built when RVC_DMEM_ARB_PERF_EN is defined.
// Rev 1.0 - initial release
// ----------------------------------------------------------------------------
`default_nettype none

module rvc_dmem_arb_5pl
  import rvc_dmem_arb_5pl_pkg::*;
#(
  parameter int HOST_MAX_WAIT = DMEM_ARB_HOST_MAX_WAIT,
  parameter int WAIT_CNT_W    = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  // core memory stage
  input  logic        core_req,
  input  logic        core_wr_en,
  input  logic [31:0] core_addr,
  input  logic [31:0] core_wr_data,
  input  logic [3:0]  core_byte_en,
  output logic        core_stall,
  output logic        core_rd_vld,
  output logic [31:0] core_rd_data,
  // host request / response
  input  logic        host_req_vld,
  output logic        host_req_rdy,
  input  logic        host_wr_en,
  input  logic [31:0] host_addr,
  input  logic [31:0] host_wr_data,
  input  logic [3:0]  host_byte_en,
  output logic        host_rsp_vld,
  input  logic        host_rsp_rdy,
  output logic [31:0] host_rsp_data,
  // D_MEM port
  output logic        mem_en,
  output logic        mem_wr_en,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wr_data,
  output logic [3:0]  mem_byte_en,
  input  logic [31:0] mem_rd_data,
  // performance counters
  output logic [15:0] perf_core_stall_cnt,
  output logic [15:0] perf_host_gnt_cnt
);

  localparam logic [WAIT_CNT_W-1:0] WAIT_LIMIT = WAIT_CNT_W'(HOST_MAX_WAIT - 1);

  t_host_state            state;
  t_host_state            state_nxt;
  logic [WAIT_CNT_W-1:0]  wait_cnt;
  logic                   forced;
  logic                   host_gnt;
  logic                   core_gnt;

  // Grants are masked while reset is asserted so the memory port is idle
  assign forced     = (wait_cnt == WAIT_LIMIT);
  assign host_gnt   = rst_n && host_req_vld && (state == H_IDLE) && (!core_req || forced);
  assign core_gnt   = rst_n && core_req && !host_gnt;
  assign core_stall = core_req && host_gnt;
  assign host_req_rdy = host_gnt;

  // Route the granted requester onto the memory port
  always_comb begin
    mem_en      = 1'b0;
    mem_wr_en   = 1'b0;
    mem_addr    = '0;
    mem_wr_data = '0;
    mem_byte_en = '0;
    if (host_gnt) begin
      mem_en      = 1'b1;
      mem_wr_en   = host_wr_en;
      mem_addr    = host_addr;
      mem_wr_data = host_wr_data;
      mem_byte_en = host_byte_en;
    end else if (core_gnt) begin
      mem_en      = 1'b1;
      mem_wr_en   = core_wr_en;
      mem_addr    = core_addr;
      mem_wr_data = core_wr_data;
      mem_byte_en = core_byte_en;
    end
  end

  // Host starvation counter, cleared when host is served or withdraws
  rvc_dmem_arb_5pl_sat_cnt #(
    .WIDTH    (WAIT_CNT_W),
    .SATURATE (1'b1),
    .MAX_VAL  (WAIT_LIMIT)
  ) u_wait_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (host_gnt || !host_req_vld),
    .inc   (host_req_vld && !host_gnt),
    .cnt   (wait_cnt)
  );

  // Core load returns one cycle after its grant (memory has 1-cycle read)
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      core_rd_vld <= 1'b0;
    end else begin
      core_rd_vld <= core_gnt && !core_wr_en;
    end
  end

  assign core_rd_data = core_rd_vld ? mem_rd_data : '0;

  // Host FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= H_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Host FSM next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      H_IDLE:  if (host_gnt) state_nxt = host_wr_en ? H_ACK : H_RD;
      H_RD:    state_nxt = H_RSP;
      H_ACK:   state_nxt = H_RSP;
      H_RSP:   if (host_rsp_rdy) state_nxt = H_IDLE;
      default: state_nxt = H_IDLE;
    endcase
  end

  // Host FSM outputs
  always_comb begin
    host_rsp_vld = (state == H_RSP);
  end

  // Response data: read word captured in H_RD, zero for write acks
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      host_rsp_data <= '0;
    end else if (state == H_RD) begin
      host_rsp_data <= mem_rd_data;
    end else if (state == H_ACK) begin
      host_rsp_data <= '0;
    end
  end

`ifdef RVC_DMEM_ARB_PERF_EN
  // Free-running wrap-around event counters
  rvc_dmem_arb_5pl_sat_cnt #(
    .WIDTH    (PERF_CNT_W),
    .SATURATE (1'b0)
  ) u_perf_stall (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (1'b0),
    .inc   (core_stall),
    .cnt   (perf_core_stall_cnt)
  );

  rvc_dmem_arb_5pl_sat_cnt #(
    .WIDTH    (PERF_CNT_W),
    .SATURATE (1'b0)
  ) u_perf_gnt (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (1'b0),
    .inc   (host_gnt),
    .cnt   (perf_host_gnt_cnt)
  );
`else
  assign perf_core_stall_cnt = 16'h0;
  assign perf_host_gnt_cnt   = 16'h0;
`endif

endmodule

`default_nettype wire
